// File: rtl/pipe_lane_pwr_seq.sv
// Lane power/clock sequencer for dynamic pipeline width reconfiguration.
// Optional power gating sequence enabled by macro LANE_PWR_GATE_EN.
module pipe_lane_pwr_seq #(
    parameter int LANES         = 4,
    parameter int DRAIN_CYCLES  = 2,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic             clkGated,
    input  logic             reset,
    input  logic             reconfig_i,
    input  logic [LANES-1:0] laneMask_i,
    output logic             stall_o,
    output logic [LANES-1:0] clkEn_o,
    output logic [LANES-1:0] pwrEn_o,
    output logic [LANES-1:0] activeMask_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int MAX_CYC = (DRAIN_CYCLES > SETTLE_CYCLES) ? DRAIN_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC + 1) : 1;

    typedef enum logic [2:0] {
        IDLE, DRAIN, CLK_OFF, PWR_OFF, PWR_ON, SETTLE, CLK_ON, DONE
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [LANES-1:0]   tgt, tgt_n;
    logic [LANES-1:0]   clk_n, act_n;
    logic               stall_n, busy_n, done_n;
`ifdef LANE_PWR_GATE_EN
    logic [LANES-1:0]   pwr, pwr_n;
    assign pwrEn_o = pwr;
`else
    assign pwrEn_o = '1;
`endif

    always_ff @(posedge clkGated) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            tgt          <= '1;
            stall_o      <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            clkEn_o      <= '1;
            activeMask_o <= '1;
`ifdef LANE_PWR_GATE_EN
            pwr          <= '1;
`endif
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            tgt          <= tgt_n;
            stall_o      <= stall_n;
            busy_o       <= busy_n;
            done_o       <= done_n;
            clkEn_o      <= clk_n;
            activeMask_o <= act_n;
`ifdef LANE_PWR_GATE_EN
            pwr          <= pwr_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        tgt_n   = tgt;
        clk_n   = clkEn_o;
        act_n   = activeMask_o;
`ifdef LANE_PWR_GATE_EN
        pwr_n   = pwr;
`endif
        case (state)
            IDLE: begin
                if (reconfig_i) begin
                    tgt_n = laneMask_i | LANES'(1);
                    if (tgt_n == activeMask_o) begin
                        state_n = DONE;
                    end else begin
                        state_n = DRAIN;
                        cnt_n   = CNT_W'(DRAIN_CYCLES - 1);
                    end
                end
            end
            DRAIN: begin
                if (cnt == '0) state_n = CLK_OFF;
                else           cnt_n   = cnt - CNT_W'(1);
            end
`ifdef LANE_PWR_GATE_EN
            CLK_OFF: state_n = PWR_OFF;
            PWR_OFF: state_n = PWR_ON;
            PWR_ON: begin
                state_n = SETTLE;
                cnt_n   = CNT_W'(SETTLE_CYCLES - 1);
            end
            SETTLE: begin
                if (cnt == '0) state_n = CLK_ON;
                else           cnt_n   = cnt - CNT_W'(1);
            end
`else
            CLK_OFF: state_n = CLK_ON;
`endif
            CLK_ON:  state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Mask updates are entry actions so each lands in the first cycle of its state.
        case (state_n)
            CLK_OFF: clk_n = clkEn_o & tgt_n;
`ifdef LANE_PWR_GATE_EN
            PWR_OFF: pwr_n = pwr & tgt_n;
            PWR_ON:  pwr_n = pwr | tgt_n;
`endif
            CLK_ON: begin
                clk_n = clkEn_o | tgt_n;
                act_n = tgt_n;
            end
            default: ;
        endcase

        stall_n = (state_n != IDLE) && (state_n != DONE);
        busy_n  = (state_n != IDLE);
        done_n  = (state_n == DONE);
    end

endmodule

// File: tb/tb_pipe_lane_pwr_seq.sv
// Self-checking bench for pipe_lane_pwr_seq: per-cycle scoreboard of a timing model
// plus an independent clock/power ordering checker.
module tb_pipe_lane_pwr_seq;

    localparam int D = 2;
    localparam int S = 3;

    typedef struct packed {
        logic       stall;
        logic       busy;
        logic       done;
        logic [3:0] clk;
        logic [3:0] pwr;
        logic [3:0] active;
    } exp_t;

    typedef struct {
        logic [3:0] mask;
        logic [3:0] tgt;
        int         ign;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       reconfig = 1'b0;
    logic [3:0] lane_mask = '0;
    logic       stall, busy, done;
    logic [3:0] clk_en, pwr_en, active_mask;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];
    logic [3:0] model_active = 4'hF;

    pipe_lane_pwr_seq #(.LANES(4), .DRAIN_CYCLES(D), .SETTLE_CYCLES(S)) dut (
        .clkGated(clk), .reset(reset), .reconfig_i(reconfig), .laneMask_i(lane_mask),
        .stall_o(stall), .clkEn_o(clk_en), .pwrEn_o(pwr_en), .activeMask_o(active_mask),
        .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    function automatic exp_t reset_rec();
        exp_t e;
        e = '{stall: 1'b0, busy: 1'b0, done: 1'b0, clk: 4'hF, pwr: 4'hF, active: 4'hF};
        return e;
    endfunction

    function automatic int latency(logic [3:0] old, logic [3:0] tgt);
        if (old == tgt) return 1;
`ifdef LANE_PWR_GATE_EN
        return D + S + 5;
`else
        return D + 3;
`endif
    endfunction

    // Expected outputs k cycles after the request cycle, straight from the timing table.
    function automatic exp_t model_at(int k, logic [3:0] old, logic [3:0] tgt);
        exp_t e;
        int   l;
        l = latency(old, tgt);
        e.stall = 1'b0; e.busy = 1'b0; e.done = 1'b0;
        e.clk = old; e.active = old;
`ifdef LANE_PWR_GATE_EN
        e.pwr = old;
`else
        e.pwr = 4'hF;
`endif
        if (old == tgt) begin
            e.busy = (k == 1);
            e.done = (k == 1);
            return e;
        end
        e.busy  = (k >= 1) && (k <= l);
        e.done  = (k == l);
        e.stall = (k >= 1) && (k <= l - 1);
        if (k >= D + 1) e.clk = old & tgt;
`ifdef LANE_PWR_GATE_EN
        if (k >= D + 2)     e.pwr = old & tgt;
        if (k >= D + 3)     e.pwr = tgt;
        if (k >= D + S + 4) begin e.clk = tgt; e.active = tgt; end
`else
        if (k >= D + 2)     begin e.clk = tgt; e.active = tgt; end
`endif
        return e;
    endfunction

    string cur_name = "reset";

    task automatic step();
        exp_t e, a;
        @(posedge clk);
        #1;
        a = '{stall: stall, busy: busy, done: done, clk: clk_en, pwr: pwr_en, active: active_mask};
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL %s: scoreboard empty", cur_name);
        end else begin
            e = sb.pop_front();
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL %s t=%0t: got stall=%b busy=%b done=%b clk=%b pwr=%b act=%b, want stall=%b busy=%b done=%b clk=%b pwr=%b act=%b",
                         cur_name, $time, a.stall, a.busy, a.done, a.clk, a.pwr, a.active,
                         e.stall, e.busy, e.done, e.clk, e.pwr, e.active);
            end
        end
    endtask

    task automatic request(input logic [3:0] mask, input logic [3:0] tgt, input int ign);
        int l;
        l = latency(model_active, tgt);
        for (int k = 1; k <= l + 1; k++) sb.push_back(model_at(k, model_active, tgt));
        reconfig  = 1'b1;
        lane_mask = mask;
        for (int k = 1; k <= l + 1; k++) begin
            step();
            reconfig  = 1'b0;
            lane_mask = 4'($urandom);
            if (k == ign) begin
                reconfig  = 1'b1;
                lane_mask = ~tgt;
            end
        end
        model_active = tgt;
    endtask

    // Ordering invariants: no power-off under a running clock, no clock-on while unpowered.
    logic [3:0] prev_clk, prev_pwr;
    logic       have_prev = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            have_prev <= 1'b0;
        end else begin
            if (have_prev) begin
                vectors++;
                if ((|(prev_pwr & ~pwr_en & (prev_clk | clk_en))) || (|(~prev_clk & clk_en & ~pwr_en))) begin
                    miscompares++;
                    $display("FAIL order t=%0t: clk %b->%b pwr %b->%b", $time, prev_clk, clk_en, prev_pwr, pwr_en);
                end
            end
            prev_clk  <= clk_en;
            prev_pwr  <= pwr_en;
            have_prev <= 1'b1;
        end
    end

    initial begin
        vec_t tbl[7];
        tbl[0] = '{mask: 4'b0011, tgt: 4'b0011, ign: 0};   // shrink
        tbl[1] = '{mask: 4'b1110, tgt: 4'b1111, ign: 4};   // grow, lane 0 forced, stray request
        tbl[2] = '{mask: 4'b0011, tgt: 4'b0011, ign: 0};
        tbl[3] = '{mask: 4'b0010, tgt: 4'b0011, ign: 0};   // no-change after forcing lane 0
        tbl[4] = '{mask: 4'b0001, tgt: 4'b0001, ign: 4};
        tbl[5] = '{mask: 4'b1111, tgt: 4'b1111, ign: 0};
        tbl[6] = '{mask: 4'b1111, tgt: 4'b1111, ign: 0};

        for (int i = 0; i < 3; i++) sb.push_back(reset_rec());
        for (int i = 0; i < 3; i++) step();
        reset = 1'b0;
        model_active = 4'hF;

        foreach (tbl[i]) begin
            cur_name = $sformatf("vec%0d", i);
            request(tbl[i].mask, tbl[i].tgt, tbl[i].ign);
        end

        // Reset in the middle of a shrink discards it.
        cur_name = "reset_mid";
        for (int k = 1; k <= 6; k++) sb.push_back(model_at(k, model_active, 4'b0011));
        reconfig  = 1'b1;
        lane_mask = 4'b0011;
        for (int k = 1; k <= 6; k++) begin
            step();
            reconfig = 1'b0;
        end
        reset = 1'b1;
        sb.push_back(reset_rec());
        step();
        reset = 1'b0;
        sb.push_back(reset_rec());
        step();
        model_active = 4'hF;

        cur_name = "after_reset";
        request(4'b0101, 4'b0101, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
